stmt_lowerer_seq_scan: RTL

Sequential bit-scanner used as the always_ff counterpart to the combinational statement-lowering fixtures. It accepts a word over a valid/ready handshake and walks it one bit per cycle under a mode-selected rule: full ones-count, or stop at the first set or first clear bit. It returns a packed result over a second valid/ready handshake. The block exercises the sequential lowering path, which the combinational fixtures do not cover:

- case on an FSM state;
- if/else-if chains;
- counters;
- struct member writes;
- register hold under back-pressure.

---
 rtl/stmt_lowerer_seq_scan_pkg.sv | 19 +
 rtl/stmt_lowerer_seq_scan.sv | 132 +++++++++++++
 2 files changed

// File: rtl/stmt_lowerer_seq_scan_pkg.sv
// Shared types for the sequential bit-scanner: FSM states and scan rules.
package stmt_lowerer_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  typedef enum logic [1:0] {
    COUNT  = 2'b00,
    FIRST1 = 2'b01,
    FIRST0 = 2'b10,
    RSVD   = 2'b11
  } scan_mode_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/stmt_lowerer_seq_scan.sv
// Walks an accepted word one bit per cycle (WIDTH cycles, or k+1 on an early hit) and returns a packed result.
// The result is held in DONE until out_ready; in_ready depends only on state, giving one bubble per word.
module stmt_lowerer_seq_scan
  import stmt_lowerer_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_found,
  output logic [IDXW-1:0] out_idx,
  output logic [IDXW:0]   out_cnt
);

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] idx;
    logic [IDXW:0]   cnt;
  } scan_result_t;

  localparam logic [IDXW-1:0] K_LAST   = IDXW'(WIDTH - 1);
  localparam logic [IDXW:0]   CNT_FULL = (IDXW + 1)'(WIDTH);

  scan_state_e     state;
  scan_mode_e      mode;
  logic [WIDTH-1:0] data;
  logic [IDXW-1:0] k;
  logic [IDXW-1:0] idx;
  logic [IDXW:0]   cnt;
  scan_result_t    res;

  logic            cur_bit;
  logic            hit;
  logic            last;
  logic            first_mode;
  logic [IDXW:0]   cnt_acc;

  assign cur_bit    = data[k];
  assign first_mode = (mode == FIRST1) || (mode == FIRST0);
  assign hit        = (mode == FIRST0) ? ~cur_bit : cur_bit;
  assign last       = (k == K_LAST);
  // Count including the bit under examination, so the final cycle can commit directly.
  assign cnt_acc    = cnt + {{IDXW{1'b0}}, cur_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mode  <= COUNT;
      data  <= '0;
      k     <= '0;
      idx   <= '0;
      cnt   <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data  <= in_data;
            mode  <= scan_mode_e'(in_mode);
            k     <= '0;
            idx   <= '0;
            cnt   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (first_mode) begin
            if (hit) begin
              res.found <= 1'b1;
              res.idx   <= k;
              res.cnt   <= {1'b0, k};
              state     <= DONE;
            end else if (last) begin
              res.found <= 1'b0;
              res.idx   <= '0;
              res.cnt   <= CNT_FULL;
              state     <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            if (cur_bit) begin
              cnt <= cnt_acc;
              idx <= k;
            end
            if (last) begin
              res.found <= (cnt_acc != '0);
              res.idx   <= cur_bit ? k : idx;
              res.cnt   <= cnt_acc;
              state     <= DONE;
            end
          end
          // Exit is decided above before stepping, so k never wraps.
          if (!last) begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign out_found = res.found;
  assign out_idx   = res.idx;
  assign out_cnt   = res.cnt;

endmodule
